// File: rtl/logic_delay_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the logic delay pipe.
// DMAX is derived from the path depths with max3.
package logic_delay_pkg;

  localparam int OR_DELAY_DEF = 5;
  localparam int CD_DELAY_DEF = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/logic_delay_pipe_if.sv
// Sample bus of the logic delay pipe: four input words with a valid flag in,
// four result fields with a valid pulse out.
interface logic_delay_pipe_if #(
  parameter int W = 4
);
  logic           in_valid;
  logic [W-1:0]   i0;
  logic [W-1:0]   i1;
  logic [W-1:0]   i2;
  logic [W-1:0]   i3;
  logic           out_valid;
  logic [W-1:0]   o0;
  logic [W-1:0]   o1;
  logic [2*W-1:0] o2;
  logic [W-1:0]   o3;

  modport master (
    output in_valid, i0, i1, i2, i3,
    input  out_valid, o0, o1, o2, o3
  );

  modport slave (
    input  in_valid, i0, i1, i2, i3,
    output out_valid, o0, o1, o2, o3
  );
endinterface

// File: rtl/logic_delay_pipe_delay_line.sv
// Fixed-depth shift register with synchronous clear; q is d delayed by DEPTH
// rising edges.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain: stage 0 captures d, every later stage takes its predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/logic_delay_pipe.sv
// Per-lane AND/OR/XOR of four words carried down delay lines to registered
// output fields, either sample-aligned (ALIGN=1) or per-path raw (ALIGN=0).
module logic_delay_pipe
  import logic_delay_pkg::*;
#(
  parameter int W        = 4,
  parameter int OR_DELAY = OR_DELAY_DEF,
  parameter int CD_DELAY = CD_DELAY_DEF,
  parameter int ALIGN    = 1
) (
  input logic             clk,
  input logic             rst,
  logic_delay_pipe_if.slave bus
);

  localparam int DMAX    = max3(1, OR_DELAY, CD_DELAY);
  // Aligned mode pads every path to DMAX so all fields leave with one sample.
  localparam int X_DEPTH = (ALIGN != 0) ? DMAX : 1;
  localparam int R_DEPTH = (ALIGN != 0) ? DMAX : OR_DELAY;
  localparam int C_DEPTH = (ALIGN != 0) ? DMAX : CD_DELAY;

  logic [W-1:0]   x_s, a_s, r_s;
  logic [2*W-1:0] c_s;
  logic [W-1:0]   x_end_s, a_end_s, r_end_s;
  logic [2*W-1:0] c_end_s;
  logic           v_end_s;
  logic [W-1:0]   o3_s;

  logic [W-1:0]   o0_r, o1_r, o3_r;
  logic [2*W-1:0] o2_r;
  logic           out_valid_r;

  assign x_s = bus.i0 ^ bus.i1;
  assign a_s = bus.i0 & bus.i1;
  assign r_s = bus.i0 | bus.i1;
  assign c_s = {bus.i2 | bus.i3, bus.i2 & bus.i3};

  delay_line #(.WIDTH(W),   .DEPTH(X_DEPTH)) u_x_line (.clk(clk), .rst(rst), .d(x_s), .q(x_end_s));
  delay_line #(.WIDTH(W),   .DEPTH(X_DEPTH)) u_a_line (.clk(clk), .rst(rst), .d(a_s), .q(a_end_s));
  delay_line #(.WIDTH(W),   .DEPTH(R_DEPTH)) u_r_line (.clk(clk), .rst(rst), .d(r_s), .q(r_end_s));
  delay_line #(.WIDTH(2*W), .DEPTH(C_DEPTH)) u_c_line (.clk(clk), .rst(rst), .d(c_s), .q(c_end_s));
  delay_line #(.WIDTH(1),   .DEPTH(DMAX))    u_v_line (.clk(clk), .rst(rst), .d(bus.in_valid), .q(v_end_s));

  // In raw mode this mixes X and C path ends from different samples on purpose.
  assign o3_s = x_end_s & (c_end_s[2*W-1:W] | c_end_s[W-1:0]);

  generate
    if (ALIGN != 0) begin : g_aligned
      // Output fields load together when a valid tag emerges, else hold.
      always_ff @(posedge clk) begin
        if (rst) begin
          o0_r        <= {W{1'b0}};
          o1_r        <= {W{1'b0}};
          o2_r        <= {(2*W){1'b0}};
          o3_r        <= {W{1'b0}};
          out_valid_r <= 1'b0;
        end else if (v_end_s) begin
          o0_r        <= c_end_s[2*W-1:W];
          o1_r        <= c_end_s[W-1:0];
          o2_r        <= {a_end_s, r_end_s};
          o3_r        <= o3_s;
          out_valid_r <= 1'b1;
        end else begin
          o0_r        <= o0_r;
          o1_r        <= o1_r;
          o2_r        <= o2_r;
          o3_r        <= o3_r;
          out_valid_r <= 1'b0;
        end
      end
    end else begin : g_raw
      // Every field follows its own path end each cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          o0_r        <= {W{1'b0}};
          o1_r        <= {W{1'b0}};
          o2_r        <= {(2*W){1'b0}};
          o3_r        <= {W{1'b0}};
          out_valid_r <= 1'b0;
        end else begin
          o0_r        <= c_end_s[2*W-1:W];
          o1_r        <= c_end_s[W-1:0];
          o2_r        <= {a_end_s, r_end_s};
          o3_r        <= o3_s;
          out_valid_r <= v_end_s;
        end
      end
    end
  endgenerate

  assign bus.o0        = o0_r;
  assign bus.o1        = o1_r;
  assign bus.o2        = o2_r;
  assign bus.o3        = o3_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_logic_delay_pipe.sv
// Bench for logic_delay_pipe: aligned, raw and W=1/depth-1 instances share one
// stimulus stream and are compared each cycle against a history-based model.
module tb_logic_delay_pipe;

  localparam int N = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_v;
  logic [3:0] drv_i0, drv_i1, drv_i2, drv_i3;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur          = -1;
  int last_rst     = -1;

  logic       h_rst [N];
  logic       h_v   [N];
  logic [3:0] h_i0  [N];
  logic [3:0] h_i1  [N];
  logic [3:0] h_i2  [N];
  logic [3:0] h_i3  [N];
  logic       pulse0 [N];
  logic [5:0] rec2  [N];

  always #5 clk = ~clk;

  logic_delay_pipe_if #(.W(4)) bus0 ();
  logic_delay_pipe_if #(.W(4)) bus1 ();
  logic_delay_pipe_if #(.W(1)) bus2 ();

  assign bus0.in_valid = drv_v;
  assign bus0.i0 = drv_i0;
  assign bus0.i1 = drv_i1;
  assign bus0.i2 = drv_i2;
  assign bus0.i3 = drv_i3;
  assign bus1.in_valid = drv_v;
  assign bus1.i0 = drv_i0;
  assign bus1.i1 = drv_i1;
  assign bus1.i2 = drv_i2;
  assign bus1.i3 = drv_i3;
  assign bus2.in_valid = drv_v;
  assign bus2.i0 = drv_i0[0];
  assign bus2.i1 = drv_i1[0];
  assign bus2.i2 = drv_i2[0];
  assign bus2.i3 = drv_i3[0];

  logic_delay_pipe #(.W(4), .OR_DELAY(5), .CD_DELAY(4), .ALIGN(1)) dut_al (.clk(clk), .rst(rst), .bus(bus0));
  logic_delay_pipe #(.W(4), .OR_DELAY(5), .CD_DELAY(4), .ALIGN(0)) dut_raw (.clk(clk), .rst(rst), .bus(bus1));
  logic_delay_pipe #(.W(1), .OR_DELAY(1), .CD_DELAY(1), .ALIGN(1)) dut_min (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur, got, exp);
    end
  endtask

  // A sample captured at edge k survives to edge t only if no reset came in between.
  function automatic bit clean(input int k);
    return (k >= 0) && (k > last_rst);
  endfunction

  function automatic logic [3:0] pathv(input int k, input int p, input logic [3:0] m);
    logic [3:0] a, b, c, e;
    a = h_i0[k] & m; b = h_i1[k] & m; c = h_i2[k] & m; e = h_i3[k] & m;
    case (p)
      0:       return a ^ b;
      1:       return a & b;
      2:       return a | b;
      3:       return c | e;
      4:       return c & e;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] rawf(input int k, input int p, input logic [3:0] m);
    return clean(k) ? pathv(k, p, m) : 4'h0;
  endfunction

  task automatic model(input int d, input int t, output logic [3:0] e0, output logic [3:0] e1,
                       output logic [3:0] eh, output logic [3:0] el, output logic [3:0] e3, output logic ev);
    int od, cd, dm, al, kk;
    logic [3:0] m;
    case (d)
      0:       begin od = 5; cd = 4; al = 1; m = 4'hF; end
      1:       begin od = 5; cd = 4; al = 0; m = 4'hF; end
      default: begin od = 1; cd = 1; al = 1; m = 4'h1; end
    endcase
    dm = (od > cd) ? od : cd;
    ev = clean(t - dm) && h_v[t - dm];
    if (al != 0) begin
      kk = -1;
      for (int k = t - dm; clean(k); k--) begin
        if (h_v[k]) begin kk = k; break; end
      end
      if (kk >= 0) begin
        e0 = pathv(kk, 3, m); e1 = pathv(kk, 4, m);
        eh = pathv(kk, 1, m); el = pathv(kk, 2, m);
        e3 = pathv(kk, 0, m) & (e0 | e1);
      end else begin
        e0 = 4'h0; e1 = 4'h0; eh = 4'h0; el = 4'h0; e3 = 4'h0;
      end
    end else begin
      e0 = rawf(t - cd, 3, m); e1 = rawf(t - cd, 4, m);
      eh = rawf(t - 1, 1, m);  el = rawf(t - od, 2, m);
      e3 = rawf(t - 1, 0, m) & (e0 | e1);
    end
  endtask

  task automatic check_all();
    logic [3:0] e0, e1, eh, el, e3;
    logic ev;
    model(0, cur, e0, e1, eh, el, e3, ev);
    check("aligned", {11'b0, bus0.out_valid, bus0.o0, bus0.o1, bus0.o2, bus0.o3},
          {11'b0, ev, e0, e1, eh, el, e3});
    model(1, cur, e0, e1, eh, el, e3, ev);
    check("raw", {11'b0, bus1.out_valid, bus1.o0, bus1.o1, bus1.o2, bus1.o3},
          {11'b0, ev, e0, e1, eh, el, e3});
    model(2, cur, e0, e1, eh, el, e3, ev);
    check("min", {26'b0, bus2.out_valid, bus2.o0, bus2.o1, bus2.o2, bus2.o3},
          {26'b0, ev, e0[0], e1[0], eh[0], el[0], e3[0]});
  endtask

  task automatic step();
    @(posedge clk);
    cur++;
    h_rst[cur] = rst; h_v[cur] = drv_v;
    h_i0[cur] = drv_i0; h_i1[cur] = drv_i1; h_i2[cur] = drv_i2; h_i3[cur] = drv_i3;
    if (rst) last_rst = cur;
    #1;
    pulse0[cur] = bus0.out_valid;
    rec2[cur]   = {bus2.out_valid, bus2.o0, bus2.o1, bus2.o2, bus2.o3};
    check_all();
  endtask

  task automatic run_to(input int target);
    while (cur < target) step();
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e);
    drv_v = v; drv_i0 = a; drv_i1 = b; drv_i2 = c; drv_i3 = e;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    int e0, cnt;
    logic [3:0] jb;

    // Reset held two cycles with live random samples.
    rst = 1'b1;
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int n = 0; n < 6; n++) begin
      step();
      check("reset_quiet", {bus0.out_valid, bus0.o0, bus0.o1, bus0.o2, bus0.o3}, 32'h0);
    end

    // Single aligned sample.
    e0 = cur;
    drive(1'b1, 4'hA, 4'h6, 4'hC, 4'h5);
    step();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    run_to(e0 + 5);
    check("single_early", 32'(bus0.out_valid), 32'h0);
    run_to(e0 + 6);
    check("single_valid", 32'(bus0.out_valid), 32'h1);
    check("single_o0", 32'(bus0.o0), 32'hD);
    check("single_o1", 32'(bus0.o1), 32'h4);
    check("single_o2", 32'(bus0.o2), 32'h2E);
    check("single_o3", 32'(bus0.o3), 32'hC);
    run_to(e0 + 8);
    check("single_hold", {bus0.out_valid, bus0.o0, bus0.o1, bus0.o2, bus0.o3}, {1'b0, 20'hD42EC});

    // Streaming: eight back-to-back random samples.
    e0 = cur;
    for (int j = 0; j < 8; j++) begin
      drive_rand(1'b1);
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    run_to(e0 + 14);
    cnt = 0;
    for (int t = e0 + 6; t <= e0 + 13; t++) cnt += int'(pulse0[t]);
    check("stream_pulses", 32'(cnt), 32'd8);
    check("stream_edges", {30'b0, pulse0[e0 + 5], pulse0[e0 + 14]}, 32'h0);

    // Reset mid-flight discards the in-flight sample.
    e0 = cur;
    drive_rand(1'b1);
    step();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    run_to(e0 + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    step();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("midrst_none", {bus0.out_valid, bus0.o0, bus0.o1, bus0.o2, bus0.o3}, 32'h0);
    run_to(e0 + 10);
    check("midrst_early", 32'(bus0.out_valid), 32'h0);
    run_to(e0 + 11);
    check("midrst_new", {bus0.out_valid, bus0.o0, bus0.o1, bus0.o2, bus0.o3}, {1'b1, 20'h70033});

    // Raw-mode per-field latencies.
    for (int n = 0; n < 8; n++) step();
    e0 = cur;
    drive(1'b1, 4'hF, 4'h0, 4'hF, 4'hF);
    for (int n = 1; n <= 8; n++) begin
      step();
      check("raw_fields", {bus1.out_valid, bus1.o0, bus1.o1, bus1.o2, bus1.o3},
            {(n >= 6), (n >= 5) ? 4'hF : 4'h0, (n >= 5) ? 4'hF : 4'h0, 4'h0,
             (n >= 6) ? 4'hF : 4'h0, (n >= 5) ? 4'hF : 4'h0});
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int n = 0; n < 8; n++) step();

    // Exhaustive one-bit sweep on the depth-1 instance.
    e0 = cur;
    for (int j = 0; j < 16; j++) begin
      jb = 4'(j);
      drive(1'b1, {3'b0, jb[0]}, {3'b0, jb[1]}, {3'b0, jb[2]}, {3'b0, jb[3]});
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    run_to(e0 + 18);
    for (int j = 0; j < 16; j++) begin
      jb = 4'(j);
      check("corner", {26'b0, rec2[e0 + j + 2]},
            {26'b0, 1'b1, jb[2] | jb[3], jb[2] & jb[3], jb[0] & jb[1], jb[0] | jb[1],
             (jb[0] ^ jb[1]) & ((jb[2] | jb[3]) | (jb[2] & jb[3]))});
    end

    // Random traffic with bubbles and occasional resets.
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 31) == 0);
      drive_rand(1'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
